// File: rtl/temperature_calc_mc.sv
// Multi-channel temperature calculator.
// Takes one tagged sign-magnitude ADC sample, computes base +/- ((|adc| * ref^2) >> SHIFT)
// with a shift-add multiplier (one magnitude bit per cycle), optionally saturates the
// result, returns it with its channel tag and updates that channel's alarm flag.
module temperature_calc_mc #(
  parameter int ADC_W    = 16,
  parameter int REF_W    = 8,
  parameter int OUT_W    = 32,
  parameter int SHIFT    = 6,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int SAT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OUT_W-1:0]    tc_base,
  input  logic [REF_W-1:0]    tc_ref,
  input  logic [OUT_W-1:0]    hi_thresh,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [OUT_W-1:0]    tempc,
  output logic [CHANNELS-1:0] alarm
);

  localparam int MAG_W = ADC_W - 1;
  localparam int ACC_W = MAG_W + 2 * REF_W;
  localparam int SUM_W = OUT_W + ADC_W + 2 * REF_W;
  localparam int CNT_W = $clog2(MAG_W + 1);

  // Saturation limits, expressed at full sum width for the clamp compare
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [MAG_W-1:0]     mag_q, mag_d;       // shifts right; bit 0 is the current multiplier bit
  logic                 sign_q, sign_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [OUT_W-1:0]     base_q, base_d;
  logic [ACC_W-1:0]     mcand_q, mcand_d;   // ref^2 pre-shifted by the current bit position
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]     tempc_q, tempc_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic [CHANNELS-1:0]  alarm_q, alarm_d;

  logic [2*REF_W-1:0]   ref2;
  logic [ACC_W-1:0]     q_full;
  logic signed [SUM_W-1:0] base_ext, q_ext, sum;
  logic [OUT_W-1:0]     result;
  logic                 over_thresh;

  // Square the reference word at full width so no product bits are lost
  assign ref2 = {{REF_W{1'b0}}, tc_ref} * {{REF_W{1'b0}}, tc_ref};

  // Final add/subtract at a width where neither operand can overflow, then clamp or wrap
  always_comb begin
    q_full   = acc_q >> SHIFT;
    base_ext = {{(SUM_W-OUT_W){base_q[OUT_W-1]}}, base_q};
    q_ext    = {{(SUM_W-ACC_W){1'b0}}, q_full};
    sum      = sign_q ? (base_ext - q_ext) : (base_ext + q_ext);
    result   = sum[OUT_W-1:0];
    if (SAT != 0) begin
      if (sum > SUM_MAX)      result = OUT_MAX;
      else if (sum < SUM_MIN) result = OUT_MIN;
    end
    over_thresh = $signed(result) > $signed(hi_thresh);
  end

  // Next-state and datapath updates for the IDLE -> MUL -> ADD -> HOLD sequence
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    sign_d   = sign_q;
    ch_d     = ch_q;
    base_d   = base_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tempc_d  = tempc_q;
    out_ch_d = out_ch_q;
    alarm_d  = alarm_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mag_d   = adc_data[ADC_W-2:0];
          sign_d  = adc_data[ADC_W-1];
          ch_d    = in_ch;
          base_d  = tc_base;
          mcand_d = {{(ACC_W-2*REF_W){1'b0}}, ref2};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (mag_q[0]) acc_d = acc_q + mcand_q;
        mag_d   = mag_q >> 1;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MAG_W - 1)) state_d = S_ADD;
      end
      S_ADD: begin
        tempc_d  = result;
        out_ch_d = ch_q;
        // Tags beyond the channel count match no bit and leave the alarms untouched
        for (int i = 0; i < CHANNELS; i++) begin
          if (32'(ch_q) == i) alarm_d[i] = over_thresh;
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight sample and clears the alarms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      ch_q     <= '0;
      base_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      tempc_q  <= '0;
      out_ch_q <= '0;
      alarm_q  <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      ch_q     <= ch_d;
      base_q   <= base_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tempc_q  <= tempc_d;
      out_ch_q <= out_ch_d;
      alarm_q  <= alarm_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out_ch    = out_ch_q;
  assign tempc     = tempc_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_temperature_calc_mc.sv
// Bench for temperature_calc_mc: a saturating and a wrapping instance driven in lockstep,
// checked every cycle against an arithmetic model, plus hand-computed literal results.
module tb_temperature_calc_mc;

  localparam int ADC_W = 16;

  logic        clk, rst;
  logic [31:0] tc_base, hi_thresh;
  logic [7:0]  tc_ref;
  logic        in_valid, out_ready;
  logic [1:0]  in_ch;
  logic [15:0] adc_data;

  logic        in_ready1, out_valid1, in_ready2, out_valid2;
  logic [1:0]  out_ch1, out_ch2;
  logic [31:0] tempc1, tempc2;
  logic [3:0]  alarm1, alarm2;

  temperature_calc_mc #(.SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .tc_base(tc_base), .tc_ref(tc_ref), .hi_thresh(hi_thresh),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ch(in_ch), .adc_data(adc_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ch(out_ch1), .tempc(tempc1),
    .alarm(alarm1));

  temperature_calc_mc #(.SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .tc_base(tc_base), .tc_ref(tc_ref), .hi_thresh(hi_thresh),
    .in_valid(in_valid), .in_ready(in_ready2), .in_ch(in_ch), .adc_data(adc_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ch(out_ch2), .tempc(tempc2),
    .alarm(alarm2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Plain-arithmetic result: base +/- floor(|adc| * ref^2 / 64), then clamp or wrap
  function automatic logic [31:0] model_temp(input logic [31:0] base, input logic [7:0] r,
                                             input logic [15:0] adc, input bit sat);
    longint mag, p, q, s, b;
    mag = longint'(adc & 16'h7FFF);
    p   = mag * longint'(r) * longint'(r);
    q   = p / 64;
    b   = longint'($signed(base));
    s   = adc[15] ? (b - q) : (b + q);
    if (sat) begin
      if (s > 64'sd2147483647)       s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
    end
    return s[31:0];
  endfunction

  // Model: 0 = waiting for a sample, 1 = computing, 2 = presenting a result
  int          m_phase;
  int          m_left;
  logic [31:0] m_t1, m_t2;
  logic [1:0]  m_ch;
  logic [3:0]  m_alarm1, m_alarm2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_left   <= 0;
      m_alarm1 <= '0;
      m_alarm2 <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_t1    <= model_temp(tc_base, tc_ref, adc_data, 1'b1);
          m_t2    <= model_temp(tc_base, tc_ref, adc_data, 1'b0);
          m_ch    <= in_ch;
          m_left  <= ADC_W;
          m_phase <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase          <= 2;
            m_alarm1[m_ch]   <= $signed(m_t1) > $signed(hi_thresh);
            m_alarm2[m_ch]   <= $signed(m_t2) > $signed(hi_thresh);
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("in_ready_sat",   in_ready1,  m_phase == 0);
      chk("in_ready_wrap",  in_ready2,  m_phase == 0);
      chk("out_valid_sat",  out_valid1, m_phase == 2);
      chk("out_valid_wrap", out_valid2, m_phase == 2);
      chk("alarm_sat",      alarm1,     m_alarm1);
      chk("alarm_wrap",     alarm2,     m_alarm2);
      if (m_phase == 2) begin
        chk("tempc_sat",  tempc1,  m_t1);
        chk("tempc_wrap", tempc2,  m_t2);
        chk("out_ch_sat", out_ch1, m_ch);
        chk("out_ch_wrap", out_ch2, m_ch);
      end
    end
  end

  // One sample through both instances; scrambles inputs after the accept
  task automatic do_txn(input string nm, input logic [1:0] ch, input logic [15:0] adc,
                        input logic [31:0] base, input logic [7:0] r,
                        input logic [31:0] exp1, input logic [31:0] exp2);
    int w, e;
    w = 0;
    while (!in_ready1 && w < 100) begin @(posedge clk); #1; w++; end
    chk({nm, "_ready_wait"}, w < 100, 1);
    tc_base = base; tc_ref = r; in_ch = ch; adc_data = adc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tc_base = $urandom; tc_ref = 8'($urandom); adc_data = 16'($urandom); in_ch = 2'($urandom);
    e = 0;
    while (!out_valid1 && e < 40) begin @(posedge clk); #1; e++; end
    chk({nm, "_latency"}, e, 16);
    chk({nm, "_tempc_sat"}, tempc1, exp1);
    chk({nm, "_tempc_wrap"}, tempc2, exp2);
    chk({nm, "_out_ch"}, out_ch1, ch);
    $display("txn %s ch=%0d adc=%h base=%h ref=%h -> tempc_sat=%h tempc_wrap=%h alarm=%b/%b",
             nm, ch, adc, base, r, tempc1, tempc2, alarm1, alarm2);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({nm, "_ready_after"}, in_ready1, 1);
      chk({nm, "_valid_after"}, out_valid1, 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; hi_thresh = 32'd30;
    tc_base = '0; tc_ref = '0; in_ch = '0; adc_data = '0;
    #1;
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_tempc", tempc1, 0);
    chk("rst_out_ch", out_ch1, 0);
    chk("rst_alarm", alarm1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1;

    do_txn("pos",      2'd1, 16'h0010, 32'd25, 8'd2, 32'd26, 32'd26);
    do_txn("neg",      2'd1, 16'h8010, 32'd25, 8'd2, 32'd24, 32'd24);
    do_txn("negzero",  2'd1, 16'h8000, 32'd25, 8'd2, 32'd25, 32'd25);
    do_txn("refzero",  2'd0, 16'h1234, 32'hFFFFFFFB, 8'd0, 32'hFFFFFFFB, 32'hFFFFFFFB);
    do_txn("ch3_hot",  2'd3, 16'h0040, 32'd25, 8'd8, 32'd89, 32'd89);
    chk("alarm_ch3", alarm1, 4'b1000);
    do_txn("ch2_hot",  2'd2, 16'h0040, 32'd25, 8'd8, 32'd89, 32'd89);
    chk("alarm_ch2_set", alarm1, 4'b1100);
    do_txn("ch2_cool", 2'd2, 16'h8000, 32'd25, 8'd8, 32'd25, 32'd25);
    chk("alarm_ch2_clr", alarm1, 4'b1000);
    do_txn("sat_hi",   2'd0, 16'h7FFF, 32'h7FFFFFF0, 8'hFF, 32'h7FFFFFFF, 32'h81FBFDF7);
    chk("alarm_sat_hi", alarm1, 4'b1001);
    chk("alarm_wrap_hi", alarm2, 4'b1000);
    do_txn("sat_lo",   2'd1, 16'hFFFF, 32'h80000010, 8'hFF, 32'h80000000, 32'h7E040209);
    chk("alarm_sat_lo", alarm1, 4'b1001);
    chk("alarm_wrap_lo", alarm2, 4'b1010);

    // Back-pressure: result must hold while out_ready is low, extra samples ignored
    out_ready = 1'b0;
    do_txn("hold", 2'd1, 16'h0010, 32'd25, 8'd2, 32'd26, 32'd26);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0); adc_data = 16'h0F00; in_ch = 2'd3; tc_base = 32'd999;
      @(posedge clk); #1;
      chk("hold_tempc", tempc1, 32'd26);
      chk("hold_out_ch", out_ch1, 2'd1);
      chk("hold_in_ready", in_ready1, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready1, 1);

    // Reset in the middle of the multiply
    tc_base = 32'd25; tc_ref = 8'd8; in_ch = 2'd2; adc_data = 16'h0040; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid1, 0);
    chk("midrst_alarm", alarm1, 0);
    chk("midrst_in_ready", in_ready1, 1);
    @(posedge clk); #1 rst = 1'b0;
    do_txn("after_rst", 2'd2, 16'h0010, 32'd25, 8'd2, 32'd26, 32'd26);
    do_txn("after_rst2", 2'd2, 16'h0040, 32'd25, 8'd8, 32'd89, 32'd89);
    chk("alarm_after_rst", alarm1, 4'b0100);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
